// File: rtl/multicore_pkg.sv
// Shared defaults, the sequencer state type and helpers for the multicore controller.
package multicore_pkg;

    localparam int N_CORES_DEF = 24;
    localparam int DATA_W_DEF  = 28;
    localparam int EN_W_DEF    = 4;
    localparam int STAGGER_DEF = 18;

    // out_en value that marks a valid result from a core
    localparam logic [3:0] EN_RESULT = 4'd1;

    typedef enum logic {
        ST_SEQ  = 1'b0,
        ST_DONE = 1'b1
    } seq_state_e;

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin search from ptr when mode=1, lowest index otherwise.
module rr_arbiter
    import multicore_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            mode,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any
);

    int w_idx;

    // Scan from the far end so the candidate closest to the start point wins.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        w_idx   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = mode ? (int'(ptr) + k) : k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (req[w_idx]) begin
                gnt_idx = ID_W'(w_idx);
                any     = 1'b1;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/multicore_ctrl.sv
// Control and collection block for a farm of rede_float cores: staggered reset
// release, one-deep result slots and an arbitrated valid/ready output stream.
module multicore_ctrl
    import multicore_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int EN_W    = EN_W_DEF,
    parameter int STAGGER = STAGGER_DEF,
    parameter bit RR_MODE = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      restart,
    output logic [N_CORES-1:0]        core_rst,
    output logic                      all_up,
    input  logic [N_CORES*DATA_W-1:0] core_data,
    input  logic [N_CORES*EN_W-1:0]   core_en,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic [EN_W-1:0]           m_en,
    output logic [id_w(N_CORES)-1:0]  m_id,
    output logic [N_CORES-1:0]        ovf
);

    localparam int ID_W  = id_w(N_CORES);
    localparam int CNT_W = id_w(STAGGER);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(STAGGER - 1);
    localparam logic [ID_W-1:0]  STAGE_LAST = ID_W'(N_CORES - 1);
    localparam logic [EN_W-1:0]  EN_HIT     = EN_W'(EN_RESULT);

    seq_state_e         r_state, w_state_next;
    logic [ID_W-1:0]    r_stage, w_stage_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               w_release;
    logic               w_all_up;
    logic [N_CORES-1:0] r_core_rst;

    logic [DATA_W-1:0]  w_core_data [N_CORES];
    logic [EN_W-1:0]    w_core_en   [N_CORES];
    logic [N_CORES-1:0] w_has_res;

    logic [DATA_W-1:0]  r_slot_data [N_CORES];
    logic [EN_W-1:0]    r_slot_en   [N_CORES];
    logic [N_CORES-1:0] r_slot_full;
    logic [N_CORES-1:0] r_ovf;

    logic [N_CORES-1:0] w_gnt;
    logic [N_CORES-1:0] w_take;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [ID_W-1:0]    r_ptr;
    logic               w_any;
    logic               w_free;

    logic               r_m_valid;
    logic [DATA_W-1:0]  r_m_data;
    logic [EN_W-1:0]    r_m_en;
    logic [ID_W-1:0]    r_m_id;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_SEQ;
            r_stage <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_stage <= w_stage_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stage_next = r_stage;
        w_cnt_next   = r_cnt;
        if (restart) begin
            w_state_next = ST_SEQ;
            w_stage_next = '0;
            w_cnt_next   = '0;
        end else if (r_state == ST_SEQ) begin
            if (r_cnt == CNT_LAST) begin
                w_cnt_next = '0;
                if (r_stage == STAGE_LAST) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_stage_next = r_stage + 1'b1;
                end
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_release = (r_state == ST_SEQ) && (r_cnt == '0);
        w_all_up  = (r_state == ST_DONE);
    end

    // Core resets only ever fall one at a time; restart raises them all again.
    always_ff @(posedge clk) begin
        if (!rst || restart) begin
            r_core_rst <= '1;
        end else if (w_release) begin
            r_core_rst[r_stage] <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CORES; gi++) begin : g_unpack
            assign w_core_data[gi] = core_data[gi*DATA_W +: DATA_W];
            assign w_core_en[gi]   = core_en[gi*EN_W +: EN_W];
            assign w_has_res[gi]   = (w_core_en[gi] == EN_HIT) && !r_core_rst[gi];
        end
    endgenerate

    rr_arbiter #(
        .N    (N_CORES),
        .ID_W (ID_W)
    ) u_arb (
        .req     (r_slot_full),
        .ptr     (r_ptr),
        .mode    (RR_MODE),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    assign w_free = !r_m_valid || m_ready;
    assign w_take = w_gnt & {N_CORES{w_free}};

    always_ff @(posedge clk) begin
        if (!rst || restart) begin
            for (int i = 0; i < N_CORES; i++) begin
                r_slot_data[i] <= '0;
                r_slot_en[i]   <= '0;
            end
            r_slot_full <= '0;
            r_ovf       <= '0;
            r_ptr       <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_en      <= '0;
            r_m_id      <= '0;
        end else begin
            // A slot being emptied this cycle can take the new result without loss.
            for (int i = 0; i < N_CORES; i++) begin
                if (w_has_res[i]) begin
                    if (!r_slot_full[i] || w_take[i]) begin
                        r_slot_data[i] <= w_core_data[i];
                        r_slot_en[i]   <= w_core_en[i];
                        r_slot_full[i] <= 1'b1;
                    end else begin
                        r_ovf[i] <= 1'b1;
                    end
                end else if (w_take[i]) begin
                    r_slot_full[i] <= 1'b0;
                end
            end
            if (w_free) begin
                if (w_any) begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= r_slot_data[w_gnt_idx];
                    r_m_en    <= r_slot_en[w_gnt_idx];
                    r_m_id    <= w_gnt_idx;
                    if (RR_MODE) begin
                        r_ptr <= (w_gnt_idx == STAGE_LAST) ? '0 : (w_gnt_idx + 1'b1);
                    end
                end else begin
                    r_m_valid <= 1'b0;
                end
            end
        end
    end

    assign core_rst = r_core_rst;
    assign all_up   = w_all_up;
    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_en     = r_m_en;
    assign m_id     = r_m_id;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_multicore_ctrl.sv
// Directed bench for multicore_ctrl (4 cores, stagger 3): a round-robin and a
// fixed-priority instance share stimulus; delivered words are scoreboarded.
module tb_multicore_ctrl;

    localparam int N  = 4;
    localparam int DW = 28;
    localparam int EW = 4;
    localparam int S  = 3;

    typedef struct packed {
        logic [1:0]    id;
        logic [EW-1:0] en;
        logic [DW-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            restart;
    logic [N*DW-1:0] core_data;
    logic [N*EW-1:0] core_en;
    logic            m_ready;

    logic [N-1:0]  rr_core_rst, fp_core_rst;
    logic          rr_all_up, fp_all_up;
    logic          rr_m_valid, fp_m_valid;
    logic [DW-1:0] rr_m_data, fp_m_data;
    logic [EW-1:0] rr_m_en, fp_m_en;
    logic [1:0]    rr_m_id, fp_m_id;
    logic [N-1:0]  rr_ovf, fp_ovf;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   mon_en   = 1'b1;

    always #5 clk = ~clk;

    multicore_ctrl #(.N_CORES(N), .DATA_W(DW), .EN_W(EW), .STAGGER(S), .RR_MODE(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .restart(restart), .core_rst(rr_core_rst), .all_up(rr_all_up),
        .core_data(core_data), .core_en(core_en), .m_valid(rr_m_valid), .m_ready(m_ready),
        .m_data(rr_m_data), .m_en(rr_m_en), .m_id(rr_m_id), .ovf(rr_ovf)
    );

    multicore_ctrl #(.N_CORES(N), .DATA_W(DW), .EN_W(EW), .STAGGER(S), .RR_MODE(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .restart(restart), .core_rst(fp_core_rst), .all_up(fp_all_up),
        .core_data(core_data), .core_en(core_en), .m_valid(fp_m_valid), .m_ready(m_ready),
        .m_data(fp_m_data), .m_en(fp_m_en), .m_id(fp_m_id), .ovf(fp_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [DW-1:0] d);
        exp_t e;
        e.id   = 2'(id);
        e.en   = 4'd1;
        e.data = d;
        sb.push_back(e);
    endtask

    // Checks any handshake due at the coming edge, then advances one cycle.
    task automatic tick();
        exp_t e;
        if (mon_en && rr_m_valid === 1'b1 && m_ready) begin
            chk("sb_word_expected", (sb.size() != 0), 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                $display("word: id=%0d data=%07h en=%0d (expected id=%0d data=%07h)",
                         rr_m_id, rr_m_data, rr_m_en, e.id, e.data);
                chk("sb_id", rr_m_id, e.id);
                chk("sb_data", rr_m_data, e.data);
                chk("sb_en", rr_m_en, e.en);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_res(input int k, input logic [DW-1:0] d, input logic [EW-1:0] e);
        core_data[k*DW +: DW] = d;
        core_en[k*EW +: EW]   = e;
    endtask

    function automatic logic [N-1:0] exp_core_rst(input int n);
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) begin
            v[k] = (n < 1 + S*k);
        end
        return v;
    endfunction

    // n counts edges since rst/restart was released.
    task automatic run_seq(input bit early);
        for (int n = 1; n <= 14; n++) begin
            if (early && n == 2) set_res(2, 28'h1234567, 4'd1);
            if (early && n == 5) set_res(2, '0, '0);
            tick();
            chk("seq_core_rst", rr_core_rst, exp_core_rst(n));
            chk("seq_all_up", rr_all_up, (n >= N*S));
            chk("seq_no_word", rr_m_valid, 1'b0);
        end
    endtask

    initial begin
        rst       = 1'b0;
        restart   = 1'b0;
        core_data = '0;
        core_en   = '0;
        m_ready   = 1'b1;
        @(negedge clk);
        tick();
        tick();

        chk("rst_core_rst", rr_core_rst, 4'b1111);
        chk("rst_all_up", rr_all_up, 1'b0);
        chk("rst_m_valid", rr_m_valid, 1'b0);
        chk("rst_m_data", rr_m_data, '0);
        chk("rst_m_en", rr_m_en, '0);
        chk("rst_m_id", rr_m_id, '0);
        chk("rst_ovf", rr_ovf, '0);

        // Release sequence, with an early result from core 2 that must be ignored
        rst = 1'b1;
        run_seq(1'b1);

        // Round-robin: three cores at once; en=3 from core 2 is not a result
        set_res(0, 28'h0000AAA, 4'd1);
        set_res(1, 28'h0000BBB, 4'd1);
        set_res(3, 28'h0000DDD, 4'd1);
        set_res(2, 28'h0000CCC, 4'd3);
        push(0, 28'h0000AAA);
        push(1, 28'h0000BBB);
        push(3, 28'h0000DDD);
        tick();
        core_en = '0;
        chk("t3_lat_slot", rr_m_valid, 1'b0);
        tick();
        chk("t3_lat_out", rr_m_valid, 1'b1);
        chk("t3_first_id", rr_m_id, 2'd0);
        tick();
        chk("t3_valid_1", rr_m_valid, 1'b1);
        tick();
        chk("t3_valid_2", rr_m_valid, 1'b1);
        tick();
        chk("t3_idle", rr_m_valid, 1'b0);

        // Pointer now past core 1: cores 0 and 3 together must yield 3 then 0
        set_res(1, 28'h0000111, 4'd1);
        push(1, 28'h0000111);
        tick();
        core_en = '0;
        tick();
        set_res(0, 28'h0000200, 4'd1);
        set_res(3, 28'h0000233, 4'd1);
        push(3, 28'h0000233);
        push(0, 28'h0000200);
        tick();
        core_en = '0;
        for (int i = 0; i < 4; i++) tick();
        chk("t3_drained", sb.size(), 0);

        // Fixed priority under continuous load from cores 0 and 3
        mon_en = 1'b0;
        for (int j = 0; j < 10; j++) begin
            set_res(0, 28'h0000100 + 28'(j), 4'd1);
            set_res(3, 28'h0000300 + 28'(j), 4'd1);
            tick();
            if (j >= 1) begin
                chk("t4_valid", fp_m_valid, 1'b1);
                chk("t4_id0", fp_m_id, 2'd0);
                chk("t4_data", fp_m_data, 28'h0000100 + 28'(j - 1));
            end
        end
        core_en = '0;
        tick();
        chk("t4_last0", fp_m_data, 28'h0000109);
        tick();
        chk("t4_id3", fp_m_id, 2'd3);
        chk("t4_old_kept", fp_m_data, 28'h0000300);
        chk("t4_fp_ovf", fp_ovf, 4'b1000);
        chk("t4_rr_ovf", rr_ovf, 4'b1001);

        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("rs_core_rst", rr_core_rst, 4'b1111);
        chk("rs_rr_ovf", rr_ovf, '0);
        chk("rs_fp_ovf", fp_ovf, '0);
        chk("rs_m_valid", rr_m_valid, 1'b0);
        run_seq(1'b0);
        mon_en = 1'b1;

        // Backpressure: word held, second result refills the slot, third overflows
        m_ready = 1'b0;
        set_res(1, 28'h0ABCDEF, 4'd1);
        push(1, 28'h0ABCDEF);
        tick();
        core_en = '0;
        tick();
        for (int h = 0; h < 5; h++) begin
            chk("t5_valid", rr_m_valid, 1'b1);
            chk("t5_data", rr_m_data, 28'h0ABCDEF);
            chk("t5_id", rr_m_id, 2'd1);
            if (h == 1) begin
                set_res(1, 28'h1111111, 4'd1);
                push(1, 28'h1111111);
            end
            if (h == 3) set_res(1, 28'h2222222, 4'd1);
            if (h == 2 || h == 4) core_en = '0;
            tick();
        end
        chk("t5_held_data", rr_m_data, 28'h0ABCDEF);
        chk("t5_ovf", rr_ovf, 4'b0010);
        m_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("t5_idle", rr_m_valid, 1'b0);
        chk("t5_drained", sb.size(), 0);

        // Load slots and ovf, then restart mid-sequence at stage 2
        m_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            set_res(0, 28'h0000500, 4'd1);
            set_res(1, 28'h0000501, 4'd1);
            set_res(3, 28'h0000503, 4'd1);
            tick();
        end
        core_en = '0;
        chk("t6_pre_ovf", rr_ovf, 4'b1011);
        chk("t6_pre_id", rr_m_id, 2'd3);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("t6_ovf_clr", rr_ovf, '0);
        chk("t6_valid_clr", rr_m_valid, 1'b0);
        for (int n = 1; n <= 7; n++) tick();
        chk("t6_stage2", rr_core_rst, 4'b1000);
        restart = 1'b1;
        tick();
        chk("t6_rst_all", rr_core_rst, 4'b1111);
        chk("t6_all_up", rr_all_up, 1'b0);
        tick();
        chk("t6_hold", rr_core_rst, 4'b1111);
        restart = 1'b0;
        m_ready = 1'b1;
        run_seq(1'b0);
        tick();
        chk("t6_no_stale", rr_m_valid, 1'b0);
        chk("t6_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
